rca_wb_sequencer: RTL and testbench
===================================

Name: rca_wb_sequencer

Overview:
- Downstream of the RCA execution unit; consumes one multi-destination RCA result per instruction.
- Serialises that result into single-port register-file writes, one accepted write per cycle at most.
- Emits a one-cycle completion pulse carrying the instruction id.
- Destination addresses are snapshotted from the per-RCA config register file at accept time.

Parameters:
- XLEN, 32, data width of each result word.
- NUM_RCAS, 3, number of selectable RCAs.
- NUM_WRITE_PORTS, 2, destination words per result.
- ID_W, 3, instruction id width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- result_valid  in  1  result offered.
- result_ready  out  1  sequencer can accept a result.
- result_rca_sel  in  $clog2(NUM_RCAS)  selects the dest-address row.
- result_id  in  ID_W  instruction id.
- result_data  in  NUM_WRITE_PORTS*XLEN  packed result words; port p occupies bits [p*XLEN +: XLEN].
- result_mask  in  NUM_WRITE_PORTS  per-port write enable.
- rca_dest_reg_addrs  in  NUM_RCAS*NUM_WRITE_PORTS*5  config dest addresses; row s, port p at [(s*NUM_WRITE_PORTS+p)*5 +: 5].
- rf_we  out  1  write request.
- rf_addr  out  5  write address.
- rf_data  out  XLEN  write data.
- rf_ack  in  1  write accepted this cycle.
- done  out  1  one-cycle completion pulse.
- done_id  out  ID_W  id of the completed instruction.
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- Reset: state IDLE; result_ready=1; rf_we=0; rf_addr=0; rf_data=0; done=0; done_id=0; busy=0; pending mask cleared.
- Accept:
  - Occurs when result_valid && result_ready.
  - Latch data, id, and the NUM_WRITE_PORTS addresses of row result_rca_sel.
  - pending = result_mask & {addr!=0 per port}. Writes to x0 are dropped silently.
- IDLE (result_ready=1):
  - Accept with pending!=0 -> WRITE.
  - Accept with pending==0 -> DONE.
- WRITE (result_ready=0, busy=1):
  - rf_we=1; drive the lowest-index set bit of pending on rf_addr/rf_data.
  - On rf_ack: clear that bit. If no bits remain -> DONE; else stay and present the next port in the following cycle.
  - Without rf_ack: hold rf_addr/rf_data stable; no timeout.
- DONE:
  - done=1 and done_id=latched id for exactly one cycle; rf_we=0; -> IDLE.
  - done_id holds its value afterwards; done returns to 0.
- Latency: with rf_ack held high, accept at cycle N, k writes at N+1..N+k, done at N+k+1. An empty pending mask gives done at N+1.
- Config rewrite mid-sequence has no effect; addresses are snapshot at accept.
- Two ports with the same address: both are written in index order, so the higher index wins.
- result_rca_sel >= NUM_RCAS: treated as pending==0 (done only, no writes).
- Reset mid-sequence: immediate return to IDLE, outstanding writes abandoned, no done pulse.

Optional Feature:
- Macro: RCA_WB_B2B_EN.
- Defined:
  - result_ready is also asserted in DONE, so a new result is accepted in the same cycle done pulses.
  - Next state from DONE is then WRITE, or DONE again with a fresh id.
  - Back-to-back results cost k+1 cycles each.
- Undefined: result_ready is high only in IDLE; each result costs k+2 cycles.

Decomposition:
- Package rca_types holds:
  - RCA_NUM_WRITE_PORTS and RCA_SEL_W constants.
  - rca_wb_state_t enum {IDLE, WRITE, DONE}.
  - Packed struct rca_result_t {sel, id, data, mask}.
- Sub-module rca_wb_pick: combinational lowest-set-bit selector. It takes the pending mask and returns a port index plus a one-hot clear vector.

Test Plan:
- Row 1 addrs {x5,x7}, mask 2'b11, data {0xBBBB,0xAAAA}, rf_ack=1 -> writes x5=0xAAAA then x7=0xBBBB on consecutive cycles; done with id=3 one cycle later.
- Addrs {x0,x9}, mask 2'b11 -> single write x9; x0 is never driven.
- mask 2'b00, id=5 -> no rf_we; done with done_id=5 one cycle after accept.
- rf_ack low for 3 cycles on the first write -> rf_addr/rf_data stable throughout; result_ready=0; next write follows the ack.
- Overwrite the config row during WRITE -> remaining writes use the snapshot addresses. Separately, assert rst mid-WRITE -> rf_we=0 and busy=0 immediately, no done pulse.
- Two back-to-back results, ack always high: with RCA_WB_B2B_EN, the second accept coincides with the first done; without the macro, there is a one-cycle gap.

Source files
------------

// File: rtl/rca_wb_sequencer_pkg.sv
// Shared types for the RCA writeback sequencer (package rca_types).
// The optional back-to-back mode is selected with RCA_WB_B2B_EN in rca_wb_sequencer.sv.
package rca_types;

    localparam int RCA_XLEN            = 32;
    localparam int RCA_NUM_RCAS        = 3;
    localparam int RCA_NUM_WRITE_PORTS = 2;
    localparam int RCA_ID_W            = 3;
    localparam int RCA_SEL_W           = (RCA_NUM_RCAS > 1) ? $clog2(RCA_NUM_RCAS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } rca_wb_state_t;

    // One result bundle as offered by the RCA execution unit.
    typedef struct packed {
        logic [RCA_SEL_W-1:0]                    sel;
        logic [RCA_ID_W-1:0]                     id;
        logic [RCA_NUM_WRITE_PORTS*RCA_XLEN-1:0] data;
        logic [RCA_NUM_WRITE_PORTS-1:0]          mask;
    } rca_result_t;

endpackage

// File: rtl/rca_wb_sequencer_pick.sv
// Lowest-set-bit selector: returns the index of the lowest pending port
// and a one-hot vector that clears exactly that bit.
module rca_wb_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     pending,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     clr
);

    // Scan from the top down so the lowest set bit is the last assignment.
    always_comb begin
        idx = '0;
        clr = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[i]) begin
                idx    = IDX_W'(i);
                clr    = '0;
                clr[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rca_wb_sequencer.sv
// Serialises one multi-destination RCA result into single-port register-file writes.
// Define RCA_WB_B2B_EN to accept the next result in the same cycle as the done pulse.
module rca_wb_sequencer
    import rca_types::*;
#(
    parameter int XLEN            = RCA_XLEN,
    parameter int NUM_RCAS        = RCA_NUM_RCAS,
    parameter int NUM_WRITE_PORTS = RCA_NUM_WRITE_PORTS,
    parameter int ID_W            = RCA_ID_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              result_valid,
    output logic                              result_ready,
    input  logic [$clog2(NUM_RCAS)-1:0]       result_rca_sel,
    input  logic [ID_W-1:0]                   result_id,
    input  logic [NUM_WRITE_PORTS*XLEN-1:0]   result_data,
    input  logic [NUM_WRITE_PORTS-1:0]        result_mask,
    input  logic [NUM_RCAS*NUM_WRITE_PORTS*5-1:0] rca_dest_reg_addrs,
    output logic                              rf_we,
    output logic [4:0]                        rf_addr,
    output logic [XLEN-1:0]                   rf_data,
    input  logic                              rf_ack,
    output logic                              done,
    output logic [ID_W-1:0]                   done_id,
    output logic                              busy
);

    localparam int IDX_W = (NUM_WRITE_PORTS > 1) ? $clog2(NUM_WRITE_PORTS) : 1;

    rca_wb_state_t state, state_nxt;

    logic [NUM_WRITE_PORTS-1:0]      pending;
    logic [NUM_WRITE_PORTS-1:0]      new_pending;
    logic [NUM_WRITE_PORTS*XLEN-1:0] lat_data;
    logic [ID_W-1:0]                 lat_id;
    logic [ID_W-1:0]                 done_id_q;
    logic [4:0]                      lat_addr [NUM_WRITE_PORTS];
    logic [4:0]                      row_addr [NUM_WRITE_PORTS];
    logic [IDX_W-1:0]                pick_idx;
    logic [NUM_WRITE_PORTS-1:0]      pick_clr;
    logic                            accept;
    logic                            last_write;

    rca_wb_pick #(
        .N     (NUM_WRITE_PORTS),
        .IDX_W (IDX_W)
    ) u_pick (
        .pending (pending),
        .idx     (pick_idx),
        .clr     (pick_clr)
    );

    // Row lookup by comparison, so an out-of-range select yields all-x0 addresses
    // and therefore an empty pending mask.
    always_comb begin
        for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
            row_addr[p] = '0;
            for (int s = 0; s < NUM_RCAS; s++) begin
                if (int'(result_rca_sel) == s)
                    row_addr[p] = rca_dest_reg_addrs[(s*NUM_WRITE_PORTS+p)*5 +: 5];
            end
            new_pending[p] = result_mask[p] && (row_addr[p] != 5'd0);
        end
    end

    assign accept     = result_valid && result_ready;
    assign last_write = ((pending & ~pick_clr) == '0);

    always_comb begin
        state_nxt    = state;
        result_ready = 1'b0;
        rf_we        = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                result_ready = 1'b1;
                if (accept)
                    state_nxt = (new_pending != '0) ? WRITE : DONE;
            end
            WRITE: begin
                rf_we = 1'b1;
                if (rf_ack && last_write)
                    state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
`ifdef RCA_WB_B2B_EN
                result_ready = 1'b1;
                if (accept)
                    state_nxt = (new_pending != '0) ? WRITE : DONE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= '0;
            lat_data  <= '0;
            lat_id    <= '0;
            done_id_q <= '0;
            for (int p = 0; p < NUM_WRITE_PORTS; p++)
                lat_addr[p] <= '0;
        end else begin
            if (accept) begin
                pending  <= new_pending;
                lat_data <= result_data;
                lat_id   <= result_id;
                for (int p = 0; p < NUM_WRITE_PORTS; p++)
                    lat_addr[p] <= row_addr[p];
            end else if (state == WRITE && rf_ack) begin
                pending <= pending & ~pick_clr;
            end
            if (state == DONE)
                done_id_q <= lat_id;
        end
    end

    // done_id shows the finishing id during DONE even if a new result lands that cycle.
    assign done_id = (state == DONE) ? lat_id : done_id_q;
    assign rf_addr = rf_we ? lat_addr[pick_idx] : 5'd0;
    assign rf_data = rf_we ? lat_data[int'(pick_idx)*XLEN +: XLEN] : '0;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_rca_wb_sequencer.sv
// Directed bench for rca_wb_sequencer; covers ordering, x0 drop, empty mask,
// stalls, config snapshot, bad select, async reset and back-to-back timing.
module tb_rca_wb_sequencer;
    import rca_types::*;

    localparam int XLEN = 32;
    localparam int NWP  = 2;
    localparam int NR   = 3;
    localparam int IDW  = 3;

    logic                clk;
    logic                rst;
    logic                result_valid;
    logic                result_ready;
    logic [1:0]          result_rca_sel;
    logic [IDW-1:0]      result_id;
    logic [NWP*XLEN-1:0] result_data;
    logic [NWP-1:0]      result_mask;
    logic [NR*NWP*5-1:0] rca_dest_reg_addrs;
    logic                rf_we;
    logic [4:0]          rf_addr;
    logic [XLEN-1:0]     rf_data;
    logic                rf_ack;
    logic                done;
    logic [IDW-1:0]      done_id;
    logic                busy;

    int checks   = 0;
    int failures = 0;

    rca_wb_sequencer dut (
        .clk                (clk),
        .rst                (rst),
        .result_valid       (result_valid),
        .result_ready       (result_ready),
        .result_rca_sel     (result_rca_sel),
        .result_id          (result_id),
        .result_data        (result_data),
        .result_mask        (result_mask),
        .rca_dest_reg_addrs (rca_dest_reg_addrs),
        .rf_we              (rf_we),
        .rf_addr            (rf_addr),
        .rf_data            (rf_data),
        .rf_ack             (rf_ack),
        .done               (done),
        .done_id            (done_id),
        .busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int s, input int p, input logic [4:0] a);
        rca_dest_reg_addrs[(s*NWP+p)*5 +: 5] = a;
    endtask

    task automatic offer(input rca_result_t r);
        result_valid   = 1'b1;
        result_rca_sel = r.sel;
        result_id      = r.id;
        result_data    = r.data;
        result_mask    = r.mask;
    endtask

    task automatic idle_in();
        result_valid = 1'b0;
    endtask

    rca_result_t r;

    initial begin
        rst                = 1'b1;
        result_valid       = 1'b0;
        result_rca_sel     = '0;
        result_id          = '0;
        result_data        = '0;
        result_mask        = '0;
        rca_dest_reg_addrs = '0;
        rf_ack             = 1'b1;
        step();
        step();
        chk("rst_ready", {31'd0, result_ready}, 32'd1);
        chk("rst_we", {31'd0, rf_we}, 32'd0);
        chk("rst_addr", {27'd0, rf_addr}, 32'd0);
        chk("rst_data", rf_data, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_done_id", {29'd0, done_id}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        step();

        // Two writes in port order, then done with id 3.
        set_addr(1, 0, 5'd5);
        set_addr(1, 1, 5'd7);
        r = '{sel: 2'd1, id: 3'd3, data: {32'hBBBB, 32'hAAAA}, mask: 2'b11};
        offer(r);
        step();
        idle_in();
        chk("t1_w0_we", {31'd0, rf_we}, 32'd1);
        chk("t1_w0_addr", {27'd0, rf_addr}, 32'd5);
        chk("t1_w0_data", rf_data, 32'hAAAA);
        chk("t1_w0_ready", {31'd0, result_ready}, 32'd0);
        chk("t1_w0_busy", {31'd0, busy}, 32'd1);
        step();
        chk("t1_w1_addr", {27'd0, rf_addr}, 32'd7);
        chk("t1_w1_data", rf_data, 32'hBBBB);
        step();
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_done_id", {29'd0, done_id}, 32'd3);
        chk("t1_done_we", {31'd0, rf_we}, 32'd0);
        step();
        chk("t1_after_done", {31'd0, done}, 32'd0);
        chk("t1_hold_id", {29'd0, done_id}, 32'd3);
        chk("t1_idle_busy", {31'd0, busy}, 32'd0);

        // x0 destination is dropped: only x9 is written.
        set_addr(0, 0, 5'd0);
        set_addr(0, 1, 5'd9);
        r = '{sel: 2'd0, id: 3'd1, data: {32'h2222, 32'h1111}, mask: 2'b11};
        offer(r);
        step();
        idle_in();
        chk("t2_we", {31'd0, rf_we}, 32'd1);
        chk("t2_addr", {27'd0, rf_addr}, 32'd9);
        chk("t2_data", rf_data, 32'h2222);
        step();
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_done_id", {29'd0, done_id}, 32'd1);
        step();

        // Empty mask: done one cycle after accept, no write.
        r = '{sel: 2'd1, id: 3'd5, data: {32'h0, 32'h0}, mask: 2'b00};
        offer(r);
        step();
        idle_in();
        chk("t3_we", {31'd0, rf_we}, 32'd0);
        chk("t3_done", {31'd0, done}, 32'd1);
        chk("t3_done_id", {29'd0, done_id}, 32'd5);
        step();
        chk("t3_done_low", {31'd0, done}, 32'd0);

        // Ack withheld for three cycles on the first write.
        set_addr(2, 0, 5'd12);
        set_addr(2, 1, 5'd13);
        rf_ack = 1'b0;
        r = '{sel: 2'd2, id: 3'd2, data: {32'h4444, 32'h3333}, mask: 2'b11};
        offer(r);
        step();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            chk("t4_stall_addr", {27'd0, rf_addr}, 32'd12);
            chk("t4_stall_data", rf_data, 32'h3333);
            chk("t4_stall_ready", {31'd0, result_ready}, 32'd0);
            if (i < 2) step();
        end
        rf_ack = 1'b1;
        step();
        chk("t4_next_addr", {27'd0, rf_addr}, 32'd13);
        chk("t4_next_data", rf_data, 32'h4444);
        step();
        chk("t4_done_id", {29'd0, done_id}, 32'd2);
        step();

        // Config rewrite after accept must not affect remaining writes.
        r = '{sel: 2'd1, id: 3'd4, data: {32'h6666, 32'h5555}, mask: 2'b11};
        offer(r);
        step();
        idle_in();
        chk("t5_first_addr", {27'd0, rf_addr}, 32'd5);
        set_addr(1, 0, 5'd20);
        set_addr(1, 1, 5'd21);
        step();
        chk("t5_snap_addr", {27'd0, rf_addr}, 32'd7);
        chk("t5_snap_data", rf_data, 32'h6666);
        step();
        chk("t5_done_id", {29'd0, done_id}, 32'd4);
        step();

        // Duplicate address: port 0 then port 1 to the same register.
        set_addr(0, 0, 5'd10);
        set_addr(0, 1, 5'd10);
        r = '{sel: 2'd0, id: 3'd6, data: {32'h8888, 32'h7777}, mask: 2'b11};
        offer(r);
        step();
        idle_in();
        chk("t6_dup0_addr", {27'd0, rf_addr}, 32'd10);
        chk("t6_dup0_data", rf_data, 32'h7777);
        step();
        chk("t6_dup1_addr", {27'd0, rf_addr}, 32'd10);
        chk("t6_dup1_data", rf_data, 32'h8888);
        step();
        chk("t6_done", {31'd0, done}, 32'd1);
        step();

        // Out-of-range select behaves as an empty mask.
        r = '{sel: 2'd3, id: 3'd7, data: {32'h1, 32'h2}, mask: 2'b11};
        offer(r);
        step();
        idle_in();
        chk("t7_we", {31'd0, rf_we}, 32'd0);
        chk("t7_done", {31'd0, done}, 32'd1);
        chk("t7_done_id", {29'd0, done_id}, 32'd7);
        step();

        // Asynchronous reset in the middle of a stalled write.
        rf_ack = 1'b0;
        r = '{sel: 2'd1, id: 3'd6, data: {32'h9, 32'h8}, mask: 2'b11};
        offer(r);
        step();
        idle_in();
        chk("t8_pre_we", {31'd0, rf_we}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t8_rst_we", {31'd0, rf_we}, 32'd0);
        chk("t8_rst_busy", {31'd0, busy}, 32'd0);
        chk("t8_rst_done", {31'd0, done}, 32'd0);
        step();
        chk("t8_no_done", {31'd0, done}, 32'd0);
        rst    = 1'b0;
        rf_ack = 1'b1;
        step();
        chk("t8_idle_ready", {31'd0, result_ready}, 32'd1);

        // Back-to-back results, one write each (row 1 port 0 is x20 now).
        r = '{sel: 2'd1, id: 3'd1, data: {32'h0, 32'hC1}, mask: 2'b01};
        offer(r);
        step();
        r = '{sel: 2'd1, id: 3'd2, data: {32'h0, 32'hC2}, mask: 2'b01};
        offer(r);
        chk("t9_w1_data", rf_data, 32'hC1);
        step();
        chk("t9_done1", {31'd0, done}, 32'd1);
        chk("t9_done1_id", {29'd0, done_id}, 32'd1);
`ifdef RCA_WB_B2B_EN
        chk("t9_ready_in_done", {31'd0, result_ready}, 32'd1);
        step();
        idle_in();
`else
        chk("t9_ready_in_done", {31'd0, result_ready}, 32'd0);
        step();
        chk("t9_gap_we", {31'd0, rf_we}, 32'd0);
        chk("t9_gap_ready", {31'd0, result_ready}, 32'd1);
        step();
        idle_in();
`endif
        chk("t9_w2_we", {31'd0, rf_we}, 32'd1);
        chk("t9_w2_addr", {27'd0, rf_addr}, 32'd20);
        chk("t9_w2_data", rf_data, 32'hC2);
        step();
        chk("t9_done2_id", {29'd0, done_id}, 32'd2);
        step();
        chk("t9_final_busy", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
